// File: rtl/alu_uart_interface.sv
// Glue between a UART byte link and a combinational ALU: gathers A, B and an op
// code from nine received bytes, captures the ALU result and sends it back LSB first.
module alu_uart_interface #(
    parameter int NB_DATA = 32,
    parameter int NB_BYTE = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_alu_data_1,
    output logic [NB_DATA-1:0] o_alu_data_2,
    output logic [NB_OP-1:0]   o_alu_ctrl,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int NB_CNT  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(N_BYTES - 1);

    typedef enum logic [2:0] {
        ST_RX_A,
        ST_RX_B,
        ST_RX_OP,
        ST_CALC,
        ST_TX_SEND,
        ST_TX_WAIT
    } state_e;

    state_e               state_q,    state_d;
    logic [NB_CNT-1:0]    cnt_q,      cnt_d;
    logic [NB_DATA-1:0]   data_1_q,   data_1_d;
    logic [NB_DATA-1:0]   data_2_q,   data_2_d;
    logic [NB_OP-1:0]     ctrl_q,     ctrl_d;
    logic [NB_DATA-1:0]   result_q,   result_d;
    logic [NB_BYTE-1:0]   tx_data_q,  tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 busy_q,     busy_d;

    // Only the low NB_OP bits of the op byte reach the ALU; the rest are discarded.
    logic unused_rx_bits;
    assign unused_rx_bits = ^i_rx_data;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_1_d   = data_1_q;
        data_2_d   = data_2_q;
        ctrl_d     = ctrl_q;
        result_d   = result_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;

        case (state_q)
            ST_RX_A: begin
                if (i_rx_done) begin
                    data_1_d[int'(cnt_q)*NB_BYTE +: NB_BYTE] = i_rx_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RX_B;
                    end else begin
                        cnt_d = cnt_q + NB_CNT'(1);
                    end
                end
            end
            ST_RX_B: begin
                if (i_rx_done) begin
                    data_2_d[int'(cnt_q)*NB_BYTE +: NB_BYTE] = i_rx_data;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RX_OP;
                    end else begin
                        cnt_d = cnt_q + NB_CNT'(1);
                    end
                end
            end
            ST_RX_OP: begin
                if (i_rx_done) begin
                    ctrl_d  = i_rx_data[NB_OP-1:0];
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                // The ALU has seen the complete operand set for one cycle; freeze its answer.
                result_d   = i_alu_result;
                cnt_d      = '0;
                tx_data_d  = i_alu_result[NB_BYTE-1:0];
                tx_start_d = 1'b1;
                state_d    = ST_TX_SEND;
            end
            ST_TX_SEND: begin
                state_d = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                if (i_tx_done) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_RX_A;
                    end else begin
                        cnt_d      = cnt_q + NB_CNT'(1);
                        tx_data_d  = result_q[int'(cnt_d)*NB_BYTE +: NB_BYTE];
                        tx_start_d = 1'b1;
                        state_d    = ST_TX_SEND;
                    end
                end
            end
            default: begin
                state_d = ST_RX_A;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == ST_CALC) || (state_d == ST_TX_SEND) || (state_d == ST_TX_WAIT);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its neighbours, matching the hardware they describe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_RX_A;
            cnt_q      <= '0;
            data_1_q   <= '0;
            data_2_q   <= '0;
            ctrl_q     <= '0;
            result_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_1_q   <= data_1_d;
            data_2_q   <= data_2_d;
            ctrl_q     <= ctrl_d;
            result_q   <= result_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
        end
    end

    assign o_alu_data_1 = data_1_q;
    assign o_alu_data_2 = data_2_q;
    assign o_alu_ctrl   = ctrl_q;
    assign o_tx_data    = tx_data_q;
    assign o_tx_start   = tx_start_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: a behavioural ALU, a UART transmitter responder and
// a byte logger around the DUT; frames come from a fixed table and from $urandom.
module tb_alu_uart_interface;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [31:0] alu_result;
    logic        tx_done;
    logic [31:0] alu_data_1;
    logic [31:0] alu_data_2;
    logic [5:0]  alu_ctrl;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        busy;

    int total = 0;
    int bad   = 0;

    alu_uart_interface #(.NB_DATA(32), .NB_BYTE(8), .NB_OP(6)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_alu_result (alu_result),
        .i_tx_done    (tx_done),
        .o_alu_data_1 (alu_data_1),
        .o_alu_data_2 (alu_data_2),
        .o_alu_ctrl   (alu_ctrl),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MIPS R-type subset; also the source of expected results.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            default: return 32'h0;
        endcase
    endfunction

    always_comb alu_result = alu_model(alu_data_1, alu_data_2, alu_ctrl);

    // Transmitter stand-in: answers each o_tx_start with i_tx_done tx_lat cycles
    // later, optionally also with a premature pulse in the o_tx_start cycle itself.
    int tx_lat      = 16;
    bit early_pulse = 1'b0;
    int done_cnt    = 0;
    initial tx_done = 1'b0;
    always @(negedge clk) begin
        tx_done = 1'b0;
        if (!rst_n) begin
            done_cnt = 0;
        end else if (tx_start) begin
            if (early_pulse) tx_done = 1'b1;
            done_cnt = tx_lat;
        end else if (done_cnt > 0) begin
            done_cnt--;
            if (done_cnt == 0) tx_done = 1'b1;
        end
    end

    // Logger: every transmitted byte, plus any back-to-back o_tx_start.
    logic [7:0] tx_log[$];
    bit         prev_start    = 1'b0;
    int         start_repeats = 0;
    always @(negedge clk) begin
        if (tx_start) begin
            tx_log.push_back(tx_data);
            if (prev_start) start_repeats++;
        end
        prev_start = tx_start;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=timeout expected=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  op_byte;
        bit          inject_rx;
        bit          early_done;
        int          lat;
        logic [5:0]  exp_ctrl;
        logic [31:0] exp_res;
    } vec_t;

    task automatic run_frame(input vec_t v, input int gap_max);
        int start;
        int cyc;
        logic [7:0] got_b;
        start       = tx_log.size();
        tx_lat      = v.lat;
        early_pulse = v.early_done;
        for (int k = 0; k < 4; k++)
            send_byte(v.a[8*k +: 8], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        for (int k = 0; k < 4; k++)
            send_byte(v.b[8*k +: 8], (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0);
        send_byte(v.op_byte, 0);
        // One negedge after the OP edge: CALC, no start yet.
        check("calc_busy",    {31'b0, busy},     32'h1);
        check("calc_nostart", {31'b0, tx_start}, 32'h0);
        check("alu_ctrl",     {26'b0, alu_ctrl}, {26'b0, v.exp_ctrl});
        check("alu_data_1",   alu_data_1,        v.a);
        check("alu_data_2",   alu_data_2,        v.b);
        @(negedge clk);
        check("first_start",  {31'b0, tx_start}, 32'h1);
        check("first_byte",   {24'b0, tx_data},  {24'b0, v.exp_res[7:0]});
        if (v.inject_rx) begin
            @(negedge clk);
            send_byte(8'hAA, 0);
        end
        cyc = 0;
        while ((busy || tx_log.size() < start + 4) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("frame_in_time", {31'b0, cyc < 3000}, 32'h1);
        repeat (3) @(negedge clk);
        check("tx_byte_count", tx_log.size() - start, 32'd4);
        for (int k = 0; k < 4; k++) begin
            got_b = (start + k < tx_log.size()) ? tx_log[start + k] : 8'hxx;
            check($sformatf("tx_byte%0d", k), {24'b0, got_b}, {24'b0, v.exp_res[8*k +: 8]});
        end
        check("idle_after_tx", {31'b0, busy}, 32'h0);
    endtask

    vec_t vecs[$];
    vec_t v;
    logic [5:0] ops[6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};

    initial begin
        rx_data = 8'h00;
        rx_done = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst_data_1",   alu_data_1,        32'h0);
        check("rst_data_2",   alu_data_2,        32'h0);
        check("rst_ctrl",     {26'b0, alu_ctrl}, 32'h0);
        check("rst_tx_data",  {24'b0, tx_data},  32'h0);
        check("rst_tx_start", {31'b0, tx_start}, 32'h0);
        check("rst_busy",     {31'b0, busy},     32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //            a             b             op     inj   early lat  ctrl   result
        vecs.push_back('{32'h3,        32'h2,        8'h20, 1'b0, 1'b0, 16, 6'h20, 32'h5});
        vecs.push_back('{32'h3,        32'h2,        8'h22, 1'b0, 1'b0, 16, 6'h22, 32'h1});
        vecs.push_back('{32'h3,        32'h2,        8'h27, 1'b0, 1'b0, 16, 6'h27, 32'hFFFF_FFFC});
        vecs.push_back('{32'hF0,       32'h0F,       8'hE5, 1'b0, 1'b0, 16, 6'h25, 32'hFF});
        vecs.push_back('{32'h10,       32'h20,       8'h20, 1'b1, 1'b0, 16, 6'h20, 32'h30});
        vecs.push_back('{32'h11223344, 32'h0,        8'h20, 1'b0, 1'b0, 16, 6'h20, 32'h11223344});
        vecs.push_back('{32'hFF00FF00, 32'h0F0F0F0F, 8'h24, 1'b0, 1'b1, 3,  6'h24, 32'h0F000F00});
        vecs.push_back('{32'h12345678, 32'hFFFFFFFF, 8'h26, 1'b0, 1'b0, 5,  6'h26, 32'hEDCBA987});
        foreach (vecs[i]) run_frame(vecs[i], 0);

        // Reset in the middle of B, between clock edges.
        for (int k = 0; k < 4; k++) send_byte(8'hDE - 8'(k), 0);
        send_byte(8'h0D, 0);
        send_byte(8'hF0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_data_1", alu_data_1,        32'h0);
        check("midrst_data_2", alu_data_2,        32'h0);
        check("midrst_busy",   {31'b0, busy},     32'h0);
        check("midrst_start",  {31'b0, tx_start}, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        run_frame('{32'h1, 32'h1, 8'h20, 1'b0, 1'b0, 16, 6'h20, 32'h2}, 0);

        // Random frames with idle gaps and random transmitter latency.
        for (int n = 0; n < 24; n++) begin
            logic [7:0] hi;
            hi           = 8'($urandom_range(3, 0));
            v.a          = $urandom;
            v.b          = $urandom;
            v.exp_ctrl   = ops[$urandom_range(5, 0)];
            v.op_byte    = {hi[1:0], v.exp_ctrl};
            v.inject_rx  = (n % 5 == 2);
            v.early_done = (n % 4 == 3);
            v.lat        = v.early_done ? 3 : int'($urandom_range(10, 2));
            v.exp_res    = alu_model(v.a, v.b, v.exp_ctrl);
            run_frame(v, 3);
        end

        check("tx_start_back_to_back", start_repeats, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
Upstream/downstream glue between the UART byte receiver/transmitter and the combinational ALU (i_data_1, i_data_2, i_ctrl -> o_out).
- Assembles two 32-bit operands and a 6-bit operation code from a stream of received bytes, and drives them to the ALU.
- Captures the ALU result and returns it to the host as four transmitted bytes.
- One command is processed at a time; receive and transmit phases never overlap.

Parameters:
NB_DATA, 32, ALU operand/result width (must be a multiple of NB_BYTE)
NB_BYTE, 8, UART byte width
NB_OP, 6, ALU control width (MIPS funct field)

Ports:
i_clk  input  1  system clock, all state updates on rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_rx_data  input  NB_BYTE  received byte, valid while i_rx_done=1
i_rx_done  input  1  one-cycle pulse, new byte on i_rx_data
i_alu_result  input  NB_DATA  ALU o_out
i_tx_done  input  1  one-cycle pulse, transmitter finished current byte
o_alu_data_1  output  NB_DATA  operand A to ALU
o_alu_data_2  output  NB_DATA  operand B to ALU
o_alu_ctrl  output  NB_OP  operation code to ALU
o_tx_data  output  NB_BYTE  byte to transmit
o_tx_start  output  1  one-cycle pulse, start transmitting o_tx_data
o_busy  output  1  high in CALC, TX_SEND and TX_WAIT

Behaviour:
Reset (i_rst_n=0, takes effect immediately, no clock needed):
- State RX_A; byte counter 0.
- All outputs 0; result register 0.

Host frame: A0 A1 A2 A3 B0 B1 B2 B3 OP. Operand bytes are little-endian (byte k goes to bits [8k+7:8k]).

States:
- RX_A: on a clock edge with i_rx_done=1, write i_rx_data into o_alu_data_1 lane[cnt]. If cnt==3: cnt<=0 and go to RX_B; else cnt++.
- RX_B: same, into o_alu_data_2. On the 4th byte go to RX_OP.
- RX_OP: on i_rx_done, o_alu_ctrl <= i_rx_data[NB_OP-1:0] (upper bits discarded); go to CALC.
- CALC: exactly one cycle. At its ending edge, result register <= i_alu_result and cnt<=0; go to TX_SEND.
- TX_SEND: exactly one cycle. o_tx_start=1 and o_tx_data = result byte[cnt]; go to TX_WAIT.
- TX_WAIT: o_tx_start=0 and o_tx_data held. On i_tx_done: if cnt==3, cnt<=0 and go to RX_A; else cnt++ and go to TX_SEND.

Rules and boundary conditions:
- o_tx_start is registered and is never high for 2 consecutive cycles.
- i_tx_done is ignored outside TX_WAIT, including in the same cycle as o_tx_start.
- i_rx_done is ignored in CALC, TX_SEND and TX_WAIT. Bytes arriving then are dropped, not queued.
- o_alu_data_1, o_alu_data_2 and o_alu_ctrl hold their values between frames and are overwritten lane-by-lane by the next frame. The ALU may see partial operands during RX; the result is sampled only in CALC.
- Latency: the edge that accepts the OP byte is edge N. The result is captured at N+1, and o_tx_start for byte 0 is high during the cycle after edge N+1.
- Result register is stable throughout TX, even if the ALU inputs change.
- Reset asserted mid-frame or mid-TX aborts everything: all state and outputs return to reset values, and the next received byte is treated as A0.
- i_rx_done held high for consecutive cycles counts as one byte per cycle.

Test Plan:
1. ADD: send 03 00 00 00 02 00 00 00 20 with a real alu instantiated and i_tx_done returned 16 cycles after each o_tx_start.
   -> o_alu_ctrl=0x20; TX bytes 05 00 00 00; four o_tx_start pulses; state returns to RX_A.
2. SUB then NOR back-to-back. SUB: A=3, B=2, OP 22 -> TX 01 00 00 00. NOR: A=3, B=2, OP 27 -> TX FC FF FF FF.
   -> Operands persist correctly and the second frame is decoded from a clean RX_A.
3. OP byte 0xE5 with A=0x000000F0, B=0x0000000F -> o_alu_ctrl=0x25 (OR); TX FF 00 00 00.
4. Pulse i_rx_done with 0xAA during TX_WAIT of a frame.
   -> Byte is dropped; after TX completes, the next frame sending A=0x11223344 gives o_alu_data_1=0x11223344.
5. Assert i_rst_n=0 after 6 bytes of a frame, between clock edges.
   -> Outputs go to 0 immediately without a clock edge. After release, a full 9-byte ADD frame (A=1, B=1) yields TX 02 00 00 00.
6. Pulse i_tx_done during the TX_SEND cycle and again 3 cycles later.
   -> Only the second pulse advances; exactly 4 bytes are sent with no skip.
